// File: rtl/pico_bus_pkg.sv
// Shared types and helpers for the PicoBus bridge: FSM state encoding,
// default error word and a slice extractor for flattened per-slave vectors.
package pico_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    // Upper bounds for get_slice: 16 slaves of up to 64 bits each.
    localparam int unsigned FLAT_MAX_W  = 1024;
    localparam int unsigned SLICE_MAX_W = 64;

    function automatic logic [SLICE_MAX_W-1:0] get_slice(
        input logic [FLAT_MAX_W-1:0] vec,
        input int unsigned           idx,
        input int unsigned           w
    );
        return SLICE_MAX_W'(vec >> (idx * w));
    endfunction

endpackage

// File: rtl/pico_bus_addr_decode.sv
// Combinational base/mask window decoder: one-hot hit vector with
// lowest-index priority on overlapping windows, plus a miss flag.
module pico_bus_addr_decode #(
    parameter int                      N_SLAVES  = 4,
    parameter logic [N_SLAVES*32-1:0]  BASE_ADDR = {N_SLAVES{32'h0000_0000}},
    parameter logic [N_SLAVES*32-1:0]  ADDR_MASK = {N_SLAVES{32'hFFFF_F000}}
) (
    input  logic [31:0]          addr,
    output logic [N_SLAVES-1:0]  hit,
    output logic                 miss
);

    // Scan from the highest index down so the lowest matching window wins.
    always_comb begin
        hit = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end else begin
                hit = hit;
            end
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/pico_bus_bridge.sv
// Registered, address-decoded PicoBus bridge with read-valid handshake and timeout.
// Optional error counter enabled by defining PICO_BUS_BRIDGE_STATS_EN.
module pico_bus_bridge
    import pico_bus_pkg::*;
#(
    parameter int                      WIDTH     = 32,
    parameter int                      N_SLAVES  = 4,
    parameter logic [N_SLAVES*32-1:0]  BASE_ADDR = {N_SLAVES{32'h0000_0000}},
    parameter logic [N_SLAVES*32-1:0]  ADDR_MASK = {N_SLAVES{32'hFFFF_F000}},
    parameter int                      TIMEOUT   = 256,
    parameter logic [31:0]             ERR_DATA  = DEFAULT_ERR_DATA
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               m_addr,
    input  logic [WIDTH-1:0]          m_din,
    input  logic                      m_wren,
    input  logic                      m_rden,
    output logic [WIDTH-1:0]          m_dout,
    output logic                      m_rvalid,
    output logic                      m_busy,
    output logic [31:0]               s_addr,
    output logic [WIDTH-1:0]          s_din,
    output logic [N_SLAVES-1:0]       s_wren,
    output logic [N_SLAVES-1:0]       s_rden,
    input  logic [N_SLAVES*WIDTH-1:0] s_dout,
    input  logic [N_SLAVES-1:0]       s_rvalid
`ifdef PICO_BUS_BRIDGE_STATS_EN
    ,
    input  logic                      err_clr,
    output logic [15:0]               err_count
`endif
);

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] ERR_W = WIDTH'(ERR_DATA);

    state_e                state_r, state_s;
    logic [31:0]           s_addr_r, s_addr_s;
    logic [WIDTH-1:0]      s_din_r, s_din_s;
    logic [N_SLAVES-1:0]   s_wren_r, s_wren_s;
    logic [N_SLAVES-1:0]   s_rden_r, s_rden_s;
    logic [WIDTH-1:0]      m_dout_r, m_dout_s;
    logic                  m_rvalid_r, m_rvalid_s;
    logic                  m_busy_r, m_busy_s;
    logic [N_SLAVES-1:0]   sel_r, sel_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [N_SLAVES-1:0]   hit_s;
    logic                  miss_s;
    logic                  sel_valid_s;
    logic                  timeout_s;
    logic [WIDTH-1:0]      rdata_s;

    pico_bus_addr_decode #(
        .N_SLAVES  (N_SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_decode (
        .addr (m_addr),
        .hit  (hit_s),
        .miss (miss_s)
    );

    assign sel_valid_s = |(s_rvalid & sel_r);
    assign timeout_s   = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Read-data mux over the one-hot selection captured when the read was issued.
    always_comb begin
        rdata_s = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_r[i]) begin
                rdata_s = rdata_s | WIDTH'(get_slice(FLAT_MAX_W'(s_dout), i, WIDTH));
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    // Next-state and next-output logic; RD_RESP accepts new requests like IDLE.
    always_comb begin
        state_s    = state_r;
        s_addr_s   = s_addr_r;
        s_din_s    = s_din_r;
        s_wren_s   = '0;
        s_rden_s   = '0;
        m_dout_s   = m_dout_r;
        m_rvalid_s = 1'b0;
        m_busy_s   = m_busy_r;
        sel_s      = sel_r;
        cnt_s      = cnt_r;
        case (state_r)
            IDLE, RD_RESP: begin
                state_s  = IDLE;
                m_busy_s = 1'b0;
                if (m_wren) begin
                    s_addr_s = m_addr;
                    s_din_s  = m_din;
                    s_wren_s = miss_s ? '0 : hit_s;
                end else if (m_rden) begin
                    // A miss waits one cycle with an empty selection, then returns ERR_DATA.
                    s_addr_s = m_addr;
                    s_rden_s = hit_s;
                    sel_s    = hit_s;
                    cnt_s    = '0;
                    m_busy_s = 1'b1;
                    state_s  = RD_WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (sel_valid_s) begin
                    m_dout_s   = rdata_s;
                    m_rvalid_s = 1'b1;
                    m_busy_s   = 1'b0;
                    state_s    = RD_RESP;
                end else if ((sel_r == '0) || timeout_s) begin
                    m_dout_s   = ERR_W;
                    m_rvalid_s = 1'b1;
                    m_busy_s   = 1'b0;
                    state_s    = RD_RESP;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            default: begin
                state_s  = IDLE;
                m_busy_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            s_addr_r   <= 32'h0000_0000;
            s_din_r    <= '0;
            s_wren_r   <= '0;
            s_rden_r   <= '0;
            m_dout_r   <= '0;
            m_rvalid_r <= 1'b0;
            m_busy_r   <= 1'b0;
            sel_r      <= '0;
            cnt_r      <= '0;
        end else begin
            state_r    <= state_s;
            s_addr_r   <= s_addr_s;
            s_din_r    <= s_din_s;
            s_wren_r   <= s_wren_s;
            s_rden_r   <= s_rden_s;
            m_dout_r   <= m_dout_s;
            m_rvalid_r <= m_rvalid_s;
            m_busy_r   <= m_busy_s;
            sel_r      <= sel_s;
            cnt_r      <= cnt_s;
        end
    end

    assign s_addr   = s_addr_r;
    assign s_din    = s_din_r;
    assign s_wren   = s_wren_r;
    assign s_rden   = s_rden_r;
    assign m_dout   = m_dout_r;
    assign m_rvalid = m_rvalid_r;
    assign m_busy   = m_busy_r;

`ifdef PICO_BUS_BRIDGE_STATS_EN
    logic        err_inc_s;
    logic [15:0] err_count_r;

    assign err_inc_s = ((state_r != RD_WAIT) && m_wren && miss_s) ||
                       ((state_r == RD_WAIT) && !sel_valid_s && ((sel_r == '0) || timeout_s));

    // Saturating error counter; a clear request wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= 16'h0000;
        end else if (err_clr) begin
            err_count_r <= 16'h0000;
        end else if (err_inc_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign err_count = err_count_r;
`endif

endmodule

// File: tb/tb_pico_bus_bridge.sv
// Scoreboard bench for pico_bus_bridge: decode, reads, misses, timeout, busy strobes, reset.
// Error-counter checks compile in when PICO_BUS_BRIDGE_STATS_EN is defined.
module tb_pico_bus_bridge;

    localparam int WIDTH    = 32;
    localparam int N_SLAVES = 4;
    localparam int TIMEOUT  = 8;
    // Slave 3 window 0x2000-0x3FFF overlaps slave 2 (0x2000-0x2FFF); slave 2 must win.
    localparam logic [N_SLAVES*32-1:0] BASE = {32'h0000_2000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [N_SLAVES*32-1:0] MASK = {32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic                      clk;
    logic                      rst_n;
    logic [31:0]               m_addr;
    logic [WIDTH-1:0]          m_din;
    logic                      m_wren;
    logic                      m_rden;
    logic [WIDTH-1:0]          m_dout;
    logic                      m_rvalid;
    logic                      m_busy;
    logic [31:0]               s_addr;
    logic [WIDTH-1:0]          s_din;
    logic [N_SLAVES-1:0]       s_wren;
    logic [N_SLAVES-1:0]       s_rden;
    logic [N_SLAVES*WIDTH-1:0] s_dout;
    logic [N_SLAVES-1:0]       s_rvalid;
`ifdef PICO_BUS_BRIDGE_STATS_EN
    logic                      err_clr;
    logic [15:0]               err_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_err     = 0;

    logic [67:0] wq[$];   // {s_wren, s_addr, s_din}
    logic [35:0] rdq[$];  // {s_rden, s_addr}
    logic [31:0] rq[$];   // m_dout

    pico_bus_bridge #(
        .WIDTH     (WIDTH),
        .N_SLAVES  (N_SLAVES),
        .BASE_ADDR (BASE),
        .ADDR_MASK (MASK),
        .TIMEOUT   (TIMEOUT),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_addr   (m_addr),
        .m_din    (m_din),
        .m_wren   (m_wren),
        .m_rden   (m_rden),
        .m_dout   (m_dout),
        .m_rvalid (m_rvalid),
        .m_busy   (m_busy),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .s_wren   (s_wren),
        .s_rden   (s_rden),
        .s_dout   (s_dout),
        .s_rvalid (s_rvalid)
`ifdef PICO_BUS_BRIDGE_STATS_EN
        ,
        .err_clr  (err_clr),
        .err_count(err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every slave strobe and read response must match a queued expectation.
    always @(negedge clk) begin
        logic [67:0] we;
        logic [35:0] re;
        logic [31:0] de;
        if (rst_n) begin
            if (|s_wren) begin
                vectors = vectors + 1;
                if (wq.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL sb_write: unexpected s_wren=%b addr=%h din=%h", s_wren, s_addr, s_din);
                end else begin
                    we = wq.pop_front();
                    if ({s_wren, s_addr, s_din} !== we) begin
                        miscompares = miscompares + 1;
                        $display("FAIL sb_write: got %h required %h", {s_wren, s_addr, s_din}, we);
                    end
                end
            end
            if (|s_rden) begin
                vectors = vectors + 1;
                if (rdq.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL sb_rden: unexpected s_rden=%b addr=%h", s_rden, s_addr);
                end else begin
                    re = rdq.pop_front();
                    if ({s_rden, s_addr} !== re) begin
                        miscompares = miscompares + 1;
                        $display("FAIL sb_rden: got %h required %h", {s_rden, s_addr}, re);
                    end
                end
            end
            if (m_rvalid) begin
                vectors = vectors + 1;
                if (rq.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL sb_rdata: unexpected m_rvalid with m_dout=%h", m_dout);
                end else begin
                    de = rq.pop_front();
                    if (m_dout !== de) begin
                        miscompares = miscompares + 1;
                        $display("FAIL sb_rdata: got %h required %h", m_dout, de);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors = vectors + 1;
        if ({s_addr, s_din, s_wren, s_rden, m_dout, m_rvalid, m_busy} !== '0) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_outputs: got %h required 0", {s_addr, s_din, s_wren, s_rden, m_dout, m_rvalid, m_busy});
        end
`ifdef PICO_BUS_BRIDGE_STATS_EN
        vectors = vectors + 1;
        if (err_count !== 16'h0000) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_err_count: got %h required 0000", err_count);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_decode();
        logic [31:0] addrs [5] = '{32'h0000_0040, 32'h0000_1FFC, 32'h0000_2010, 32'h0000_3004, 32'hF000_0000};
        logic [3:0]  hits  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        logic [31:0] d;
        m_addr = 32'h0000_1004; m_din = 32'h0000_A5A5; m_wren = 1'b1;
        wq.push_back({4'b0010, 32'h0000_1004, 32'h0000_A5A5});
        tick();
        m_wren = 1'b0;
        vectors = vectors + 1;
        if (s_wren !== 4'b0010 || s_addr !== 32'h0000_1004 || s_din !== 32'h0000_A5A5 || m_busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL write_decode: wren=%b addr=%h din=%h busy=%b required 0010/00001004/0000a5a5/0", s_wren, s_addr, s_din, m_busy);
        end
        tick();
        vectors = vectors + 1;
        if (s_wren !== 4'b0000) begin
            miscompares = miscompares + 1;
            $display("FAIL write_pulse_width: s_wren=%b required 0000", s_wren);
        end
        // Back-to-back writes, including overlap priority and a dropped miss.
        for (int i = 0; i < 5; i++) begin
            d = $urandom;
            m_addr = addrs[i]; m_din = d; m_wren = 1'b1;
            if (hits[i] != 4'b0000) wq.push_back({hits[i], addrs[i], d});
            else exp_err = exp_err + 1;
            tick();
        end
        m_wren = 1'b0;
        tick();
        tick();
        vectors = vectors + 1;
        if (wq.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL write_b2b_drain: %0d writes missing required 0", wq.size());
        end
`ifdef PICO_BUS_BRIDGE_STATS_EN
        vectors = vectors + 1;
        if (err_count !== 16'(exp_err)) begin
            miscompares = miscompares + 1;
            $display("FAIL write_miss_count: got %0d required %0d", err_count, exp_err);
        end
`endif
    endtask

    task automatic test_read_hit();
        m_addr = 32'h0000_2010; m_rden = 1'b1;
        rdq.push_back({4'b0100, 32'h0000_2010});
        rq.push_back(32'h0000_1234);
        tick();
        m_rden = 1'b0;
        vectors = vectors + 1;
        if (m_busy !== 1'b1 || m_rvalid !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL read_busy_c1: busy=%b rvalid=%b required 1/0", m_busy, m_rvalid);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            vectors = vectors + 1;
            if (m_busy !== 1'b1 || m_rvalid !== 1'b0) begin
                miscompares = miscompares + 1;
                $display("FAIL read_busy_c%0d: busy=%b rvalid=%b required 1/0", c, m_busy, m_rvalid);
            end
            case (c)
                2: begin s_rvalid = 4'b1001; s_dout = {N_SLAVES{32'hBAD0_BAD0}}; end
                5: begin s_rvalid = 4'b0100; s_dout = '0; s_dout[64 +: 32] = 32'h0000_1234; end
                default: s_rvalid = 4'b0000;
            endcase
        end
        tick();
        s_rvalid = 4'b0000;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_busy !== 1'b0 || m_dout !== 32'h0000_1234) begin
            miscompares = miscompares + 1;
            $display("FAIL read_resp: rvalid=%b busy=%b dout=%h required 1/0/00001234", m_rvalid, m_busy, m_dout);
        end
        tick();
        vectors = vectors + 1;
        if (m_rvalid !== 1'b0 || m_dout !== 32'h0000_1234) begin
            miscompares = miscompares + 1;
            $display("FAIL read_hold: rvalid=%b dout=%h required 0/00001234", m_rvalid, m_dout);
        end
        // Minimum latency: slave 0 answers the cycle after s_rden.
        m_addr = 32'h0000_0008; m_rden = 1'b1;
        rdq.push_back({4'b0001, 32'h0000_0008});
        rq.push_back(32'h600D_0001);
        tick();
        m_rden = 1'b0;
        tick();
        s_rvalid = 4'b0001; s_dout = '0; s_dout[0 +: 32] = 32'h600D_0001;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL read_min_early: rvalid=%b required 0", m_rvalid);
        end
        tick();
        s_rvalid = 4'b0000;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_dout !== 32'h600D_0001) begin
            miscompares = miscompares + 1;
            $display("FAIL read_min_latency: rvalid=%b dout=%h required 1/600d0001", m_rvalid, m_dout);
        end
        tick();
    endtask

    task automatic test_read_miss();
        m_addr = 32'hF000_0000; m_rden = 1'b1;
        rq.push_back(32'hDEAD_BEEF);
        exp_err = exp_err + 1;
        tick();
        m_rden = 1'b0;
        vectors = vectors + 1;
        if (m_busy !== 1'b1 || m_rvalid !== 1'b0 || s_rden !== 4'b0000) begin
            miscompares = miscompares + 1;
            $display("FAIL miss_c1: busy=%b rvalid=%b rden=%b required 1/0/0000", m_busy, m_rvalid, s_rden);
        end
        tick();
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_busy !== 1'b0 || m_dout !== 32'hDEAD_BEEF) begin
            miscompares = miscompares + 1;
            $display("FAIL miss_resp: rvalid=%b busy=%b dout=%h required 1/0/deadbeef", m_rvalid, m_busy, m_dout);
        end
`ifdef PICO_BUS_BRIDGE_STATS_EN
        vectors = vectors + 1;
        if (err_count !== 16'(exp_err)) begin
            miscompares = miscompares + 1;
            $display("FAIL miss_count: got %0d required %0d", err_count, exp_err);
        end
`endif
        tick();
    endtask

    task automatic test_timeout();
        m_addr = 32'h0000_1000; m_rden = 1'b1;
        rdq.push_back({4'b0010, 32'h0000_1000});
        rq.push_back(32'hDEAD_BEEF);
        exp_err = exp_err + 1;
        tick();
        m_rden = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            vectors = vectors + 1;
            if (m_rvalid !== 1'b0 || m_busy !== 1'b1) begin
                miscompares = miscompares + 1;
                $display("FAIL timeout_wait_c%0d: rvalid=%b busy=%b required 0/1", c, m_rvalid, m_busy);
            end
            tick();
        end
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_dout !== 32'hDEAD_BEEF) begin
            miscompares = miscompares + 1;
            $display("FAIL timeout_resp: rvalid=%b dout=%h required 1/deadbeef", m_rvalid, m_dout);
        end
        tick();
        s_rvalid = 4'b0010; s_dout = '0; s_dout[32 +: 32] = 32'h0000_1111;
        tick();
        tick();
        s_rvalid = 4'b0000;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b0 || m_busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL timeout_late_valid: rvalid=%b busy=%b required 0/0", m_rvalid, m_busy);
        end
        // Valid in the same cycle as the timeout returns real data.
        m_addr = 32'h0000_1000; m_rden = 1'b1;
        rdq.push_back({4'b0010, 32'h0000_1000});
        rq.push_back(32'h5555_AAAA);
        tick();
        m_rden = 1'b0;
        for (int c = 1; c <= TIMEOUT; c++) begin
            if (c == TIMEOUT) begin
                s_rvalid = 4'b0010; s_dout = '0; s_dout[32 +: 32] = 32'h5555_AAAA;
            end
            tick();
        end
        s_rvalid = 4'b0000;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_dout !== 32'h5555_AAAA) begin
            miscompares = miscompares + 1;
            $display("FAIL timeout_precedence: rvalid=%b dout=%h required 1/5555aaaa", m_rvalid, m_dout);
        end
`ifdef PICO_BUS_BRIDGE_STATS_EN
        vectors = vectors + 1;
        if (err_count !== 16'(exp_err)) begin
            miscompares = miscompares + 1;
            $display("FAIL timeout_count: got %0d required %0d", err_count, exp_err);
        end
`endif
        tick();
    endtask

    task automatic test_busy_strobes();
        m_addr = 32'h0000_0004; m_rden = 1'b1;
        rdq.push_back({4'b0001, 32'h0000_0004});
        rq.push_back(32'hCAFE_0001);
        tick();
        m_rden = 1'b0; m_wren = 1'b1; m_addr = 32'h0000_1000; m_din = 32'h0000_0BAD;
        tick();
        m_wren = 1'b0; m_rden = 1'b1; m_addr = 32'h0000_2000;
        vectors = vectors + 1;
        if (s_wren !== 4'b0000 || m_busy !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL busy_wren_ignored: wren=%b busy=%b required 0000/1", s_wren, m_busy);
        end
        tick();
        m_rden = 1'b0;
        s_rvalid = 4'b0001; s_dout = '0; s_dout[0 +: 32] = 32'hCAFE_0001;
        vectors = vectors + 1;
        if (s_rden !== 4'b0000) begin
            miscompares = miscompares + 1;
            $display("FAIL busy_rden_ignored: rden=%b required 0000", s_rden);
        end
        tick();
        s_rvalid = 4'b0000;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_dout !== 32'hCAFE_0001) begin
            miscompares = miscompares + 1;
            $display("FAIL busy_read_resp: rvalid=%b dout=%h required 1/cafe0001", m_rvalid, m_dout);
        end
        tick();
        // Simultaneous write and read in IDLE: write wins.
        m_addr = 32'h0000_3004; m_din = 32'h0000_0F0F; m_wren = 1'b1; m_rden = 1'b1;
        wq.push_back({4'b1000, 32'h0000_3004, 32'h0000_0F0F});
        tick();
        m_wren = 1'b0; m_rden = 1'b0;
        vectors = vectors + 1;
        if (s_wren !== 4'b1000 || s_rden !== 4'b0000 || m_busy !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL write_wins: wren=%b rden=%b busy=%b required 1000/0000/0", s_wren, s_rden, m_busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        m_addr = 32'h0000_2020; m_rden = 1'b1;
        rdq.push_back({4'b0100, 32'h0000_2020});
        tick();
        m_rden = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        exp_err = 0;
        #1;
        vectors = vectors + 1;
        if ({s_addr, s_din, s_wren, s_rden, m_dout, m_rvalid, m_busy} !== '0) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_mid_read: got %h required 0", {s_addr, s_din, s_wren, s_rden, m_dout, m_rvalid, m_busy});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        m_addr = 32'h0000_3100; m_rden = 1'b1;
        rdq.push_back({4'b1000, 32'h0000_3100});
        rq.push_back(32'h7777_0000);
        tick();
        m_rden = 1'b0;
        tick();
        s_rvalid = 4'b1000; s_dout = '0; s_dout[96 +: 32] = 32'h7777_0000;
        tick();
        s_rvalid = 4'b0000;
        vectors = vectors + 1;
        if (m_rvalid !== 1'b1 || m_dout !== 32'h7777_0000) begin
            miscompares = miscompares + 1;
            $display("FAIL read_after_reset: rvalid=%b dout=%h required 1/77770000", m_rvalid, m_dout);
        end
        tick();
        tick();
`ifdef PICO_BUS_BRIDGE_STATS_EN
        m_addr = 32'hF000_0000; m_wren = 1'b1;
        tick();
        m_wren = 1'b0;
        tick();
        vectors = vectors + 1;
        if (err_count !== 16'h0001) begin
            miscompares = miscompares + 1;
            $display("FAIL err_count_after_reset: got %0d required 1", err_count);
        end
        err_clr = 1'b1; m_wren = 1'b1;
        tick();
        err_clr = 1'b0; m_wren = 1'b0;
        tick();
        vectors = vectors + 1;
        if (err_count !== 16'h0000) begin
            miscompares = miscompares + 1;
            $display("FAIL err_clr_priority: got %0d required 0", err_count);
        end
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        m_addr   = 32'h0000_0000;
        m_din    = '0;
        m_wren   = 1'b0;
        m_rden   = 1'b0;
        s_dout   = '0;
        s_rvalid = '0;
`ifdef PICO_BUS_BRIDGE_STATS_EN
        err_clr  = 1'b0;
`endif
        test_reset();
        test_write_decode();
        test_read_hit();
        test_read_miss();
        test_timeout();
        test_busy_strobes();
        test_reset_mid_read();
        vectors = vectors + 1;
        if (wq.size() != 0 || rdq.size() != 0 || rq.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL sb_drain: pending writes=%0d rdens=%0d reads=%0d required 0/0/0", wq.size(), rdq.size(), rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pico_bus_bridge.md
Name: pico_bus_bridge

Overview:
- Registered, address-decoded successor to the OR-reduced PicoBus fan-out.
- One PicoBus master port drives N_SLAVES slave ports, each with its own base/mask window.
- Each access is strobed only to the hit slave. A read-valid handshake replaces the fixed-latency OR of slave outputs, with a timeout and error data for unmapped or silent slaves.
- Sits between the PCIe-side PicoBus master and the user register blocks.

Parameters:
- WIDTH, 32, data width of din/dout.
- N_SLAVES, 4, number of slave ports (1..16).
- BASE_ADDR, {N_SLAVES{32'h0}}, flattened N_SLAVES×32 base address per slave; slave i owns bits [32i+31:32i].
- ADDR_MASK, {N_SLAVES{32'hFFFF_F000}}, flattened per-slave mask; hit_i = ((addr & mask_i) == base_i).
- TIMEOUT, 256, cycles to wait for s_rvalid before aborting a read (≥2).
- ERR_DATA, 32'hDEAD_BEEF, returned on a decode miss or timeout (zero-extended or truncated to WIDTH).

Ports:
- clk, in, 1, bridge clock.
- rst_n, in, 1, asynchronous active-low reset.
- m_addr, in, 32, master address.
- m_din, in, WIDTH, master write data.
- m_wren, in, 1, master write strobe.
- m_rden, in, 1, master read strobe.
- m_dout, out, WIDTH, read data, valid only with m_rvalid.
- m_rvalid, out, 1, one-cycle read-response pulse.
- m_busy, out, 1, high while a read is outstanding; master strobes are ignored while high.
- s_addr, out, 32, registered address broadcast to all slaves.
- s_din, out, WIDTH, registered write data broadcast.
- s_wren, out, N_SLAVES, one-hot write strobe.
- s_rden, out, N_SLAVES, one-hot read strobe.
- s_dout, in, N_SLAVES×WIDTH, flattened slave read data.
- s_rvalid, in, N_SLAVES, per-slave read-data valid.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE. All outputs 0: s_addr, s_din, s_wren, s_rden, m_dout, m_rvalid, m_busy. Timeout counter 0.
- Decode: priority to the lowest index on overlapping windows. No hit = miss.
- FSM states: IDLE, RD_WAIT, RD_RESP.
- IDLE, m_wren=1 (write):
  - Cycle+1: s_addr/s_din registered; s_wren[hit] pulses one cycle.
  - Posted write; m_busy stays 0; back-to-back writes every cycle are allowed.
  - A miss drops the write silently.
- IDLE, m_rden=1 (read):
  - Cycle+1: s_addr registered; s_rden[hit] pulses one cycle; m_busy=1; → RD_WAIT.
  - On a miss: no s_rden; → RD_RESP with data=ERR_DATA.
- IDLE, m_wren and m_rden both high: write wins; read ignored.
- RD_WAIT:
  - Counter increments each cycle.
  - s_rvalid[hit]=1 → latch s_dout[hit], → RD_RESP.
  - Counter reaches TIMEOUT-1 without valid → latch ERR_DATA, → RD_RESP.
  - s_rvalid from non-selected slaves is ignored.
  - A valid arriving in the same cycle as timeout takes precedence (real data returned).
- RD_RESP: m_rvalid=1 and m_dout=latched data for exactly one cycle; m_busy=0 in that same cycle; → IDLE.
- Minimum read latency, m_rden to m_rvalid: 3 cycles (slave responds the cycle after s_rden).
- Master strobes while m_busy=1 are ignored, not queued.
- Counter width: $clog2(TIMEOUT+1). Counter clears on entry to RD_WAIT.
- m_dout holds its last value between responses.
- Reset mid-read: abort; no m_rvalid is generated.

Optional Feature:
- Macro: PICO_BUS_BRIDGE_STATS_EN.
- Defined:
  - Extra output err_count[15:0], saturating at 16'hFFFF. Increments once per read miss, dropped write, or timeout.
  - Extra input err_clr (synchronous, takes priority over increment).
  - Both reset to 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package pico_bus_pkg:
  - state enum typedef (IDLE, RD_WAIT, RD_RESP);
  - default ERR_DATA constant;
  - function to extract slice i of a flattened vector.
- Sub-module pico_bus_addr_decode (combinational): addr, BASE_ADDR, ADDR_MASK → one-hot hit vector plus miss flag, lowest-index priority. Instantiated once in pico_bus_bridge.

Test Plan:
- Write decode: N_SLAVES=4, BASE_ADDR[1]=32'h1000, mask FFFF_F000. Write 32'hA5A5 to 32'h1004 → s_wren=4'b0010 one cycle later; s_din=32'hA5A5; s_addr=32'h1004.
- Read, slave 2 responds 4 cycles after s_rden with 32'h1234 → m_rvalid pulses once with m_dout=32'h1234; m_busy high from cycle+1 until the response cycle.
- Unmapped read at 32'hF000_0000 → no s_rden; m_rvalid at cycle+2 with m_dout=32'hDEAD_BEEF; err_count=1 when STATS_EN is defined.
- Timeout: TIMEOUT=8, slave never asserts s_rvalid → m_rvalid with ERR_DATA exactly 8 cycles after entering RD_WAIT. A late s_rvalid afterwards is ignored.
- Strobes during busy: m_rden and m_wren pulsed while m_busy=1 → no s_rden/s_wren activity. Simultaneous m_wren+m_rden in IDLE → only s_wren asserted.
- Reset in RD_WAIT: rst_n low mid-wait → all outputs 0 immediately. After release, a new read completes normally with no stale m_rvalid.
